irq_ctrl: RTL and testbench
===========================

IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 4, number of external interrupt lines (2..8).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-004 SHALL have port irq  input  NUM_IRQ  raw asynchronous interrupt lines, rising-edge triggered.
REQ-005 SHALL have port global_en  input  1  global interrupt enable from machine status.
REQ-006 SHALL have port en_wr  input  1  one-cycle write strobe for the enable mask.
REQ-007 SHALL have port en_data  input  NUM_IRQ  new enable mask value.
REQ-008 SHALL have port ack  input  1  one-cycle pulse from the control stage when it begins servicing ext_int.
REQ-009 SHALL have port enable  output  NUM_IRQ  current enable mask.
REQ-010 SHALL have port pending  output  NUM_IRQ  current pending flags.
REQ-011 SHALL have port ext_int  output  1  registered request to the control stage.
REQ-012 SHALL have port cause  output  clog2(NUM_IRQ)  index of the line being requested, valid while ext_int=1.

Function
REQ-013 SHALL pass each irq bit through a 2-flop synchronizer plus one history flop; an edge is sync2=1 and hist=0.
REQ-014 SHALL set pending[i] on the clock edge where edge[i] is detected; a line held high sets pending only once.
REQ-015 SHALL, for irq rising before edge k, first set pending at edge k+2 and assert ext_int at edge k+3.
REQ-016 SHALL update enable to en_data on any edge with en_wr=1; mask change affects ext_int from the next edge.
REQ-017 SHALL implement FSM states IDLE, REQ, HOLD.
REQ-018 IDLE -> REQ when global_en=1 and (pending & enable) nonzero; cause latched to the lowest set index of (pending & enable).
REQ-019 ext_int SHALL be 1 only in REQ; cause SHALL remain constant for the whole REQ residency.
REQ-020 REQ -> HOLD on ack=1: pending[cause] cleared on the same edge.
REQ-021 REQ -> IDLE without clearing pending when global_en=0 or enable[cause]=0 (and ack=0); ack wins if simultaneous.
REQ-022 HOLD -> IDLE unconditionally after one cycle; ext_int=0 in HOLD so the control stage never samples a serviced request twice.
REQ-023 ack in IDLE or HOLD SHALL be ignored (no pending change).
REQ-024 If edge[cause] and ack coincide, pending[cause] SHALL remain 1 (new event wins over clear).
REQ-025 Edges on other lines during REQ/HOLD SHALL set their pending bits and be served after returning to IDLE by lowest-index priority.
REQ-026 pending bits of masked lines SHALL still set and persist; unmasking later raises the request.

Reset
REQ-027 reset low SHALL immediately force state=IDLE, ext_int=0, cause=0, pending=0, enable=0, and all synchronizer/history flops=0.
REQ-028 A line already high at reset release SHALL generate one pending event (history starts at 0).
REQ-029 reset asserted during REQ SHALL drop ext_int immediately with no pending retained; no ack is required.

Verification
REQ-030 enable=4'b0011, global_en=1, irq[1] rises -> pending=4'b0010 at k+2, ext_int=1, cause=1 at k+3; ack pulse -> pending=0, ext_int=0, one HOLD cycle, then IDLE.
REQ-031 irq[3] and irq[1] rise together, enable=4'b1111 -> cause=1 served first; after ack + HOLD, ext_int re-asserts with cause=3.
REQ-032 global_en=0, irq[0] rises -> pending[0]=1, ext_int stays 0; global_en set to 1 -> ext_int=1, cause=0 one edge later.
REQ-033 In REQ with cause=2, en_wr clears bit 2 -> ext_int=0 next edge, pending[2] still 1; re-enable -> ext_int=1, cause=2.
REQ-034 ack coincident with new detected edge on cause line -> pending[cause] stays 1, ext_int re-asserts after HOLD.
REQ-035 reset pulsed low mid-REQ (asynchronous, between edges) -> ext_int, pending, enable read 0 before next clk edge; irq held high through release -> one fresh pending event.

Source files
------------

// File: rtl/irq_ctrl.sv
// Purpose: collects rising-edge interrupts into pending flags and raises one masked, prioritised request at a time.
// Latency: irq rising before edge k sets pending at edge k+2. ext_int follows at edge k+3.
// Backpressure: a request stays up until ack. Withdrawing the mask or global_en drops it and keeps it pending.
module irq_ctrl #(
    parameter int NUM_IRQ = 4,
    parameter int CW      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               global_en,
    input  logic               en_wr,
    input  logic [NUM_IRQ-1:0] en_data,
    input  logic               ack,
    output logic [NUM_IRQ-1:0] enable,
    output logic [NUM_IRQ-1:0] pending,
    output logic               ext_int,
    output logic [CW-1:0]      cause
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Synchronizer and history chain, one flop stage each.
    logic [NUM_IRQ-1:0] sync1_q;
    logic [NUM_IRQ-1:0] sync2_q;
    logic [NUM_IRQ-1:0] hist_q;
    logic [NUM_IRQ-1:0] edge_det;

    // Architectural state.
    logic [NUM_IRQ-1:0] enable_q,  enable_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    state_t             state_q,   state_d;
    logic [CW-1:0]      cause_q,   cause_d;
    logic               ext_int_q, ext_int_d;

    // Arbitration helpers.
    logic [NUM_IRQ-1:0] req_vec;
    logic [CW-1:0]      low_idx;
    logic               ack_clr;
    logic [NUM_IRQ-1:0] clr_mask;

    // Bring raw lines into the clock domain. A history flop follows for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            hist_q  <= '0;
        end else begin
            sync1_q <= irq;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    // The history flop resets to 0, so a line already high at reset release counts as one event.
    assign edge_det = sync2_q & ~hist_q;

    // A software write to the enable mask takes effect on the same edge.
    always_comb begin
        enable_d = enable_q;
        if (en_wr) begin
            enable_d = en_data;
        end
    end

    // Candidate requests are pending lines that are also unmasked.
    assign req_vec = pending_q & enable_q;

    // Fixed priority: the lowest set index wins.
    // The descending scan lets the last hit, the lowest index, overwrite.
    always_comb begin
        low_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req_vec[i]) begin
                low_idx = CW'(i);
            end
        end
    end

    // Request FSM: next state, latched cause and the ack-driven clear.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        ack_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (global_en && (|req_vec)) begin
                    state_d = REQ;
                    cause_d = low_idx;
                end
            end
            REQ: begin
                // ack has priority over a request withdrawn by mask or global_en.
                if (ack) begin
                    state_d = HOLD;
                    ack_clr = 1'b1;
                end else if (!global_en || !enable_q[cause_q]) begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                // One dead cycle so a serviced request is never sampled twice.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Build the pending update. A coincident new edge on the cause line beats the clear.
    always_comb begin
        clr_mask = '0;
        if (ack_clr) begin
            clr_mask = {{(NUM_IRQ-1){1'b0}}, 1'b1} << cause_q;
        end
        pending_d = (pending_q & ~clr_mask) | edge_det;
    end

    // Register ext_int directly from the next state, so the output comes straight from a flop.
    assign ext_int_d = (state_d == REQ);

    // State, mask, pending and request registers. Reset clears everything immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cause_q   <= '0;
            ext_int_q <= 1'b0;
            enable_q  <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            ext_int_q <= ext_int_d;
            enable_q  <= enable_d;
            pending_q <= pending_d;
        end
    end

    assign enable  = enable_q;
    assign pending = pending_q;
    assign ext_int = ext_int_q;
    assign cause   = cause_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Purpose: directed bench for irq_ctrl with hand-computed expectations at each step.
// Latency: inputs are driven 1ns after a rising edge. Outputs are sampled at the same point.
// Backpressure: none. ack is driven as a one-cycle pulse by the bench.
module tb_irq_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] irq;
    logic       global_en;
    logic       en_wr;
    logic [3:0] en_data;
    logic       ack;
    logic [3:0] enable;
    logic [3:0] pending;
    logic       ext_int;
    logic [1:0] cause;

    int passed;
    int total;

    irq_ctrl #(.NUM_IRQ(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .irq       (irq),
        .global_en (global_en),
        .en_wr     (en_wr),
        .en_data   (en_data),
        .ack       (ack),
        .enable    (enable),
        .pending   (pending),
        .ext_int   (ext_int),
        .cause     (cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_en(input logic [3:0] m);
        en_wr   = 1'b1;
        en_data = m;
        tick();
        en_wr   = 1'b0;
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        reset     = 1'b0;
        irq       = '0;
        global_en = 1'b0;
        en_wr     = 1'b0;
        en_data   = '0;
        ack       = 1'b0;
        #2;
        chk("rst_ext", {7'd0, ext_int}, 8'd0);
        chk("rst_pend", {4'd0, pending}, 8'd0);
        chk("rst_en", {4'd0, enable}, 8'd0);
        chk("rst_cause", {6'd0, cause}, 8'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Single line: irq[1], mask 0011.
        wr_en(4'b0011);
        chk("t1_enable", {4'd0, enable}, 8'h03);
        global_en = 1'b1;
        irq = 4'b0010;
        tick();                                       // edge k
        tick();                                       // k+1
        chk("t1_pend_k1", {4'd0, pending}, 8'h00);
        tick();                                       // k+2
        chk("t1_pend_k2", {4'd0, pending}, 8'h02);
        chk("t1_ext_k2", {7'd0, ext_int}, 8'd0);
        tick();                                       // k+3
        chk("t1_ext_k3", {7'd0, ext_int}, 8'd1);
        chk("t1_cause", {6'd0, cause}, 8'd1);
        tick();
        chk("t1_ext_wait", {7'd0, ext_int}, 8'd1);
        ack = 1'b1;
        tick();                                       // HOLD
        ack = 1'b0;
        chk("t1_hold_ext", {7'd0, ext_int}, 8'd0);
        chk("t1_hold_pend", {4'd0, pending}, 8'h00);
        tick();                                       // IDLE
        chk("t1_idle_ext", {7'd0, ext_int}, 8'd0);
        tick();
        chk("t1_held_once", {4'd0, pending}, 8'h00);
        irq = '0;
        tick(); tick(); tick();

        // Two lines rise together: lowest index first.
        wr_en(4'b1111);
        irq = 4'b1010;
        tick(); tick(); tick();
        chk("t2_pend", {4'd0, pending}, 8'h0a);
        tick();
        chk("t2_ext1", {7'd0, ext_int}, 8'd1);
        chk("t2_cause1", {6'd0, cause}, 8'd1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("t2_hold_ext", {7'd0, ext_int}, 8'd0);
        chk("t2_hold_pend", {4'd0, pending}, 8'h08);
        tick();
        chk("t2_idle_ext", {7'd0, ext_int}, 8'd0);
        tick();
        chk("t2_ext3", {7'd0, ext_int}, 8'd1);
        chk("t2_cause3", {6'd0, cause}, 8'd3);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("t2_pend_clr", {4'd0, pending}, 8'h00);
        tick();
        irq = '0;
        tick(); tick(); tick();

        // Global enable gating, an ack ignored in IDLE, and withdrawal by global_en.
        global_en = 1'b0;
        irq = 4'b0001;
        tick(); tick(); tick();
        chk("t3_pend", {4'd0, pending}, 8'h01);
        tick();
        chk("t3_ext_gated", {7'd0, ext_int}, 8'd0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("t3_ack_idle", {4'd0, pending}, 8'h01);
        global_en = 1'b1;
        tick();
        chk("t3_ext", {7'd0, ext_int}, 8'd1);
        chk("t3_cause", {6'd0, cause}, 8'd0);
        global_en = 1'b0;
        tick();
        chk("t3_withdraw_ext", {7'd0, ext_int}, 8'd0);
        chk("t3_withdraw_pend", {4'd0, pending}, 8'h01);
        global_en = 1'b1;
        tick();
        chk("t3_reraise", {7'd0, ext_int}, 8'd1);
        ack = 1'b1;
        tick();                                       // HOLD
        chk("t3_clr", {4'd0, pending}, 8'h00);
        tick();                                       // ack still high in HOLD
        ack = 1'b0;
        chk("t3_ack_hold", {4'd0, pending}, 8'h00);
        chk("t3_idle_ext", {7'd0, ext_int}, 8'd0);
        irq = '0;
        tick(); tick(); tick();

        // Mask withdrawal while in REQ, then re-enable.
        irq = 4'b0100;
        tick(); tick(); tick(); tick();
        chk("t4_ext", {7'd0, ext_int}, 8'd1);
        chk("t4_cause", {6'd0, cause}, 8'd2);
        wr_en(4'b1011);
        chk("t4_en_wr", {4'd0, enable}, 8'h0b);
        tick();
        chk("t4_masked_ext", {7'd0, ext_int}, 8'd0);
        chk("t4_masked_pend", {4'd0, pending}, 8'h04);
        wr_en(4'b1111);
        tick();
        chk("t4_reen_ext", {7'd0, ext_int}, 8'd1);
        chk("t4_reen_cause", {6'd0, cause}, 8'd2);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        irq = '0;
        tick(); tick(); tick();

        // ack coincides with a new edge on the cause line.
        irq = 4'b0001;
        tick(); tick(); tick(); tick();               // k..k+3
        chk("t5_ext", {7'd0, ext_int}, 8'd1);
        irq = 4'b0000;
        tick();                                       // k+4
        irq = 4'b0001;
        tick();                                       // k+5
        tick();                                       // k+6
        ack = 1'b1;
        tick();                                       // k+7: ack and edge together
        ack = 1'b0;
        chk("t5_hold_ext", {7'd0, ext_int}, 8'd0);
        chk("t5_pend_kept", {4'd0, pending}, 8'h01);
        tick();
        chk("t5_idle_ext", {7'd0, ext_int}, 8'd0);
        tick();
        chk("t5_reassert", {7'd0, ext_int}, 8'd1);
        chk("t5_cause", {6'd0, cause}, 8'd0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        irq = '0;
        tick(); tick(); tick();

        // Asynchronous reset mid-REQ, with the line held high through release.
        irq = 4'b0100;
        tick(); tick(); tick(); tick();
        chk("t6_ext", {7'd0, ext_int}, 8'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_async_ext", {7'd0, ext_int}, 8'd0);
        chk("t6_async_pend", {4'd0, pending}, 8'h00);
        chk("t6_async_en", {4'd0, enable}, 8'h00);
        chk("t6_async_cause", {6'd0, cause}, 8'd0);
        tick();
        reset = 1'b1;
        tick();                                       // j
        tick();                                       // j+1
        chk("t6_pend_j1", {4'd0, pending}, 8'h00);
        tick();                                       // j+2
        chk("t6_pend_j2", {4'd0, pending}, 8'h04);
        chk("t6_masked_ext", {7'd0, ext_int}, 8'd0);
        wr_en(4'b0100);
        chk("t6_en", {4'd0, enable}, 8'h04);
        tick();
        chk("t6_unmask_ext", {7'd0, ext_int}, 8'd1);
        chk("t6_unmask_cause", {6'd0, cause}, 8'd2);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick(); tick();
        chk("t6_once", {4'd0, pending}, 8'h00);
        chk("t6_final_ext", {7'd0, ext_int}, 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
